// File: rtl/cim_arb_pkg.sv
// Shared types and width helpers for the CIM tile-group arbiter.
package cim_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GRANT    = 2'd1,
    ST_WAIT_CIM = 2'd2
  } arb_state_t;

  localparam int NUM_REQ_DEF   = 4;
  localparam int MAX_BURST_DEF = 1024;

  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst) + 1;
  endfunction

  localparam int OWNER_W = owner_w(NUM_REQ_DEF);
  localparam int CNT_W   = cnt_w(MAX_BURST_DEF);

endpackage

// File: rtl/cim_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at ptr, ptr+1, ... wrapping.
module rr_picker
  import cim_arb_pkg::*;
#(
  parameter int N = NUM_REQ_DEF,
  parameter int W = OWNER_W
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_onehot,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  always_comb begin : pick_loop
    int j;
    j        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_valid && i_req[j]) begin
        o_valid     = 1'b1;
        o_idx       = W'(j);
        o_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cim_arbiter.sv
// Round-robin arbiter multiplexing layer-controller write bursts onto one CIM tile group.
module cim_arbiter
  import cim_arb_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int BUS_WIDTH   = 16,
  parameter int V_CIM_TILES = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int MAX_BURST   = MAX_BURST_DEF
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_REQ-1:0]                               i_req,
  input  logic [NUM_REQ-1:0]                               i_we,
  input  logic [NUM_REQ-1:0][BUS_WIDTH*V_CIM_TILES-1:0]    i_data,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]               i_addr,
  input  logic [NUM_REQ-1:0]                               i_done,
  input  logic                                             i_cim_ready,
  output logic [NUM_REQ-1:0]                               o_gnt,
  output logic [owner_w(NUM_REQ)-1:0]                      o_owner,
  output logic                                             o_cim_we,
  output logic [BUS_WIDTH*V_CIM_TILES-1:0]                 o_cim_data,
  output logic [ADDR_WIDTH-1:0]                            o_cim_addr,
  output logic                                             o_err,
  output arb_state_t                                       o_state
);

  localparam int OW = owner_w(NUM_REQ);
  localparam int DW = BUS_WIDTH * V_CIM_TILES;
  localparam int CW = cnt_w(MAX_BURST);

  arb_state_t          r_state, w_state_nxt;
  logic [OW-1:0]       r_ptr, w_ptr_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic                r_seen_low, w_seen_low_nxt;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic [OW-1:0]       r_owner, w_owner_nxt;
  logic                r_cim_we, w_cim_we_nxt;
  logic [DW-1:0]       r_cim_data, w_cim_data_nxt;
  logic [ADDR_WIDTH-1:0] r_cim_addr, w_cim_addr_nxt;
  logic                r_err, w_err_nxt;

  logic [NUM_REQ-1:0]  w_pick_onehot;
  logic [OW-1:0]       w_pick_idx;
  logic                w_pick_valid;

  rr_picker #(.N(NUM_REQ), .W(OW)) u_pick (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_cnt_nxt      = r_cnt;
    w_seen_low_nxt = r_seen_low;
    w_gnt_nxt      = r_gnt;
    w_owner_nxt    = r_owner;
    w_cim_we_nxt   = 1'b0;
    w_cim_data_nxt = r_cim_data;
    w_cim_addr_nxt = r_cim_addr;
    w_err_nxt      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_valid && i_cim_ready) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = w_pick_onehot;
          w_owner_nxt = w_pick_idx;
          w_ptr_nxt   = (w_pick_idx == OW'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        // A dropped request aborts the burst ahead of done or watchdog.
        if (!i_req[r_owner]) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end else begin
          w_cim_we_nxt   = i_we[r_owner];
          w_cim_data_nxt = i_data[r_owner];
          w_cim_addr_nxt = i_addr[r_owner];
          if (i_done[r_owner]) begin
            w_state_nxt    = ST_WAIT_CIM;
            w_seen_low_nxt = 1'b0;
          end else if (r_cnt == CW'(MAX_BURST - 1)) begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_err_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      ST_WAIT_CIM: begin
        // Grant is held until the tiles have gone busy and come back idle.
        if (!i_cim_ready) begin
          w_seen_low_nxt = 1'b1;
        end else if (r_seen_low) begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_seen_low <= 1'b0;
      r_gnt      <= '0;
      r_owner    <= '0;
      r_cim_we   <= 1'b0;
      r_cim_data <= '0;
      r_cim_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_seen_low <= w_seen_low_nxt;
      r_gnt      <= w_gnt_nxt;
      r_owner    <= w_owner_nxt;
      r_cim_we   <= w_cim_we_nxt;
      r_cim_data <= w_cim_data_nxt;
      r_cim_addr <= w_cim_addr_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign o_gnt      = r_gnt;
  assign o_owner    = r_owner;
  assign o_cim_we   = r_cim_we;
  assign o_cim_data = r_cim_data;
  assign o_cim_addr = r_cim_addr;
  assign o_err      = r_err;
  assign o_state    = r_state;

endmodule

// File: doc/cim_arbiter.md
CIM_ARBITER -- requirements
Module: cim_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of layer controllers sharing one CIM tile group.
REQ-002 SHALL have parameter BUS_WIDTH, default 16, meaning the per-tile write bus width.
REQ-003 SHALL have parameter V_CIM_TILES, default 8, meaning the vertical tile count; the data bus is BUS_WIDTH*V_CIM_TILES bits.
REQ-004 SHALL have parameter ADDR_WIDTH, default 4, meaning the CIM write-address width.
REQ-005 SHALL have parameter MAX_BURST, default 1024, meaning the watchdog limit in cycles for a GRANT phase.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port i_req, input, NUM_REQ bits: per-requester access request, level-sensitive.
REQ-009 SHALL have port i_we, input, NUM_REQ bits: per-requester CIM write enable.
REQ-010 SHALL have port i_data, input, [NUM_REQ][BUS_WIDTH*V_CIM_TILES]: per-requester write data.
REQ-011 SHALL have port i_addr, input, [NUM_REQ][ADDR_WIDTH]: per-requester write address.
REQ-012 SHALL have port i_done, input, NUM_REQ bits: one-cycle pulse marking the last write of a burst.
REQ-013 SHALL have port i_cim_ready, input, 1 bit: CIM tiles idle; low while computing.
REQ-014 SHALL have port o_gnt, output, NUM_REQ bits: one-hot or zero grant vector.
REQ-015 SHALL have port o_owner, output, $clog2(NUM_REQ) bits: index of the granted requester.
REQ-016 SHALL have port o_cim_we, output, 1 bit: registered write enable to the CIM.
REQ-017 SHALL have port o_cim_data, output, BUS_WIDTH*V_CIM_TILES bits: registered data to the CIM.
REQ-018 SHALL have port o_cim_addr, output, ADDR_WIDTH bits: registered address to the CIM.
REQ-019 SHALL have port o_err, output, 1 bit: one-cycle pulse on watchdog expiry.

Function
REQ-020 SHALL implement FSM states IDLE, GRANT, WAIT_CIM.
REQ-021 IDLE: when any i_req is high and i_cim_ready=1, SHALL select a winner by round-robin from priority pointer ptr, assert o_gnt[winner] and o_owner=winner on the next edge, and enter GRANT.
REQ-022 Round-robin rule: SHALL pick the first set i_req at index ptr, ptr+1, ... (wrapping modulo NUM_REQ); on grant, ptr SHALL become winner+1 mod NUM_REQ.
REQ-023 GRANT: SHALL register the granted requester's i_we, i_data and i_addr onto o_cim_we, o_cim_data and o_cim_addr with exactly 1-cycle latency.
REQ-024 SHALL ignore i_we, i_data, i_addr and i_done from non-granted requesters; o_cim_we SHALL be 0 outside GRANT.
REQ-025 GRANT: on i_done[owner]=1, SHALL forward that cycle's write, then enter WAIT_CIM.
REQ-026 WAIT_CIM: SHALL keep o_gnt and o_owner so the owner can read the output buffer, and wait for i_cim_ready to fall, then rise.
REQ-027 WAIT_CIM: on that rise, SHALL clear o_gnt and return to IDLE; the next grant is possible no earlier than 1 cycle later.
REQ-028 Abort: if i_req[owner] falls in GRANT, SHALL force o_cim_we=0 from the next cycle, clear o_gnt, and return to IDLE without a WAIT_CIM phase.
REQ-029 Watchdog: SHALL count cycles in GRANT; at count MAX_BURST-1 without i_done, SHALL pulse o_err, clear o_gnt and go IDLE; ptr SHALL still advance past the owner.
REQ-030 Simultaneous events: i_done[owner] SHALL take priority over the watchdog in the same cycle; falling i_req[owner] SHALL take priority over i_done.
REQ-031 o_gnt SHALL never have more than one bit set.
REQ-032 The watchdog counter SHALL be $clog2(MAX_BURST)+1 bits wide and clear on every entry to GRANT.

Reset
REQ-033 While rst=1, SHALL asynchronously force: state=IDLE, ptr=0, counter=0, o_gnt=0, o_owner=0, o_cim_we=0, o_cim_data=0, o_cim_addr=0, o_err=0.
REQ-034 Reset mid-burst SHALL drop the grant immediately, with no write emitted after rst asserts.

Structure
REQ-035 Package cim_arb_pkg SHALL hold the state enum typedef and the derived widths (OWNER_W, CNT_W).
REQ-036 SHALL contain one combinational sub-module rr_picker: inputs req vector and ptr, outputs one-hot winner, index and valid.

Verification
REQ-037 Reset, then i_req=4'b0110 with i_cim_ready=1 -> o_gnt=4'b0010 and o_owner=1 one cycle later; ptr becomes 2.
REQ-038 Owner 1 drives i_we=1, i_addr=3, i_data=0xA5.. -> o_cim_addr=3 and o_cim_data=0xA5.. with o_cim_we=1 on the next cycle; i_we[2]=1 produces nothing.
REQ-039 i_done[1] pulse, then i_cim_ready 1->0->1 -> o_gnt stays 4'b0010 until the rise, then 0; the next grant goes to requester 2.
REQ-040 All four requesters held high across 8 bursts -> grant order 0,1,2,3,0,1,2,3 after reset.
REQ-041 MAX_BURST=16, owner never pulses i_done -> o_err=1 for one cycle at the 16th GRANT cycle, o_gnt=0.
REQ-042 rst asserted mid-GRANT with o_cim_we=1 -> all outputs 0 asynchronously; after release, i_req=4'b0001 -> grant to requester 0.
